bus_slave_if: RTL and testbench

Serial bus slave port: the downstream consumer of the bus master's serial frames on the shared open-drain `b_BUS` line. It decodes the start bit, address and RW, acknowledges frames addressed to its device ID, and executes the access on a simple parallel local port. For a write it delivers address and data to the local port; for a read it fetches a byte from the local port and shifts it back to the master. One instance sits in front of each slave peripheral.

---
 rtl/bus_slave_if_if.sv | 27 ++
 rtl/bus_slave_if.sv | 146 ++++++++++++++
 tb/tb_bus_slave_if.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_if_if.sv
// Signal bundle between bus_slave_if, the bus master control lines and the local peripheral port.
// The open-drain b_BUS line is not bundled here; it stays a plain inout so it resolves on the board net.
interface bus_slave_if_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDRS_WIDTH = 15,
   parameter int ID_WIDTH    = 3
);
   logic                            b_RW;
   logic                            b_bus_utilizing;
   logic [ADDRS_WIDTH-ID_WIDTH-1:0] s_address;
   logic [DATA_WIDTH-1:0]           s_dout;
   logic                            s_write;
   logic                            s_read;
   logic [DATA_WIDTH-1:0]           s_din;
   logic                            s_rvalid;
   logic                            s_busy;

   modport slave (
      input  b_RW, b_bus_utilizing, s_din, s_rvalid,
      output s_address, s_dout, s_write, s_read, s_busy
   );

   modport master (
      output b_RW, b_bus_utilizing, s_din, s_rvalid,
      input  s_address, s_dout, s_write, s_read, s_busy
   );
endinterface

// File: rtl/bus_slave_if.sv
// Serial bus slave: decodes start bit, address and RW, acks frames for SLAVE_ID and
// runs the write or read on the local parallel port, shifting read data back on b_BUS.
module bus_slave_if #(
   parameter int                  DATA_WIDTH  = 8,
   parameter int                  ADDRS_WIDTH = 15,
   parameter int                  ID_WIDTH    = 3,
   parameter logic [ID_WIDTH-1:0] SLAVE_ID    = 3'd5,
   parameter int                  TIMEOUT_LEN = 6
) (
   input  logic          clk,
   input  logic          rst,
   inout  wire           b_BUS,
   bus_slave_if_if.slave bus
);

   localparam int LADDR_W = ADDRS_WIDTH - ID_WIDTH;
   localparam int CNT_W   = $clog2(ADDRS_WIDTH + DATA_WIDTH + 2);

   localparam logic [CNT_W-1:0] ADDR_LAST     = CNT_W'(ADDRS_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST     = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] ACK_LAST      = CNT_W'(1);
   localparam logic [CNT_W-1:0] PAYLOAD_FIRST = CNT_W'(2);
   localparam logic [CNT_W-1:0] SEND_LAST     = CNT_W'(DATA_WIDTH + 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_CHK, ACK_ADDR, WR_START, WR_DATA,
      WR_COMMIT, ACK_DATA, RD_REQ, RD_WAIT, RD_SEND
   } state_t;

   state_t                 state, next_state;
   logic [ADDRS_WIDTH-1:0] addr_sr;
   logic [DATA_WIDTH-1:0]  data_sr;
   logic [DATA_WIDTH-1:0]  s_dout_q;
   logic [LADDR_W-1:0]     s_address_q;
   logic                   rw_q;
   logic [CNT_W-1:0]       cnt;
   logic [TIMEOUT_LEN-1:0] tmo_cnt;
   logic                   bus_oe, bus_do, bus_in;
   logic                   wr_stb, rd_stb;
   logic                   tmo_done, id_hit, start_bit;

   assign bus_in    = b_BUS;
   assign b_BUS     = bus_oe ? bus_do : 1'bz;
   assign tmo_done  = &tmo_cnt;
   assign id_hit    = (addr_sr[ADDRS_WIDTH-1 -: ID_WIDTH] == SLAVE_ID);
   assign start_bit = bus.b_bus_utilizing && !bus_in;

   assign bus.s_address = s_address_q;
   assign bus.s_dout    = s_dout_q;
   assign bus.s_write   = wr_stb;
   assign bus.s_read    = rd_stb;
   assign bus.s_busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      next_state = state;
      bus_oe     = 1'b0;
      bus_do     = 1'b1;
      wr_stb     = 1'b0;
      rd_stb     = 1'b0;
      case (state)
         IDLE:      if (start_bit) next_state = ADDR;
         ADDR:      if (cnt == ADDR_LAST) next_state = ADDR_CHK;
         ADDR_CHK:  next_state = id_hit ? ACK_ADDR : IDLE;
         ACK_ADDR: begin
            bus_oe = 1'b1;
            bus_do = 1'b0;
            if (cnt == ACK_LAST) next_state = rw_q ? WR_START : RD_REQ;
         end
         WR_START: begin
            if (start_bit)     next_state = WR_DATA;
            else if (tmo_done) next_state = IDLE;
         end
         WR_DATA:   if (cnt == DATA_LAST) next_state = WR_COMMIT;
         WR_COMMIT: begin
            wr_stb     = 1'b1;
            next_state = ACK_DATA;
         end
         ACK_DATA: begin
            bus_oe = 1'b1;
            bus_do = (cnt != '0);
            if (cnt == ACK_LAST) next_state = IDLE;
         end
         RD_REQ: begin
            rd_stb     = 1'b1;
            next_state = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.s_rvalid)  next_state = RD_SEND;
            else if (tmo_done) next_state = IDLE;
         end
         RD_SEND: begin
            // Preamble 0 then 1, then the captured byte MSB first from the top of data_sr.
            bus_oe = 1'b1;
            if (cnt == '0)           bus_do = 1'b0;
            else if (cnt == ACK_LAST) bus_do = 1'b1;
            else                     bus_do = data_sr[DATA_WIDTH-1];
            if (cnt == SEND_LAST) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // Master dropping the bus aborts any frame; strobes decided above still fire this cycle.
      if (state != IDLE && !bus.b_bus_utilizing) next_state = IDLE;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (rst) begin
         addr_sr     <= '0;
         data_sr     <= '0;
         s_address_q <= '0;
         s_dout_q    <= '0;
         rw_q        <= 1'b0;
         cnt         <= '0;
         tmo_cnt     <= '0;
      end else begin
         if (state == IDLE || next_state != state) begin
            cnt     <= '0;
            tmo_cnt <= '0;
         end else begin
            cnt     <= cnt + 1'b1;
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         case (state)
            ADDR: begin
               addr_sr <= {addr_sr[ADDRS_WIDTH-2:0], bus_in};
               if (cnt == ADDR_LAST) rw_q <= bus.b_RW;
            end
            ADDR_CHK: if (id_hit && bus.b_bus_utilizing) s_address_q <= addr_sr[LADDR_W-1:0];
            WR_DATA: begin
               data_sr <= {data_sr[DATA_WIDTH-2:0], bus_in};
               if (cnt == DATA_LAST) s_dout_q <= {data_sr[DATA_WIDTH-2:0], bus_in};
            end
            RD_WAIT: if (bus.s_rvalid) data_sr <= bus.s_din;
            RD_SEND: if (cnt >= PAYLOAD_FIRST) data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_slave_if.sv
// Self-checking bench for bus_slave_if: acts as bus master and local peripheral, and compares
// every cycle against expectations derived from the frame timing rules.
module tb_bus_slave_if;
   localparam int            DW  = 8;
   localparam int            AW  = 15;
   localparam int            IW  = 3;
   localparam int            TL  = 6;
   localparam int            TMO = 1 << TL;
   localparam logic [IW-1:0] SID = 3'd5;

   typedef struct {
      logic [AW-1:0]    addr;
      logic             rw;
      logic [DW-1:0]    data;
      int               gap;       // write: start-bit delay after WR_START entry; read: s_rvalid delay after s_read
      int               abort_at;  // cycle where b_bus_utilizing drops, -1 for none
      int               rst_at;    // cycle where rst is high, -1 for none
      bit               early_rv;  // also pulse s_rvalid in the s_read cycle with wrong data
      logic [AW-IW-1:0] exp_addr;  // s_address after the frame
   } vec_t;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             m_oe  = 1'b0;
   logic             m_val = 1'b1;
   wire              b_BUS;
   int               errors = 0;
   int               checks = 0;
   logic [AW-IW-1:0] addr_model = '0;
   vec_t             vecs[10];

   bus_slave_if_if #(.DATA_WIDTH(DW), .ADDRS_WIDTH(AW), .ID_WIDTH(IW)) bus ();

   assign b_BUS = m_oe ? m_val : 1'bz;
   pullup (b_BUS);

   bus_slave_if #(
      .DATA_WIDTH(DW), .ADDRS_WIDTH(AW), .ID_WIDTH(IW), .SLAVE_ID(SID), .TIMEOUT_LEN(TL)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .b_BUS(b_BUS),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [AW-1:0] addr, input logic rw, input logic [DW-1:0] data,
                               input int gap, input int abort_at, input int rst_at,
                               input bit early_rv, input logic [AW-IW-1:0] exp_addr);
      vec_t v;
      v.addr = addr; v.rw = rw; v.data = data; v.gap = gap;
      v.abort_at = abort_at; v.rst_at = rst_at; v.early_rv = early_rv; v.exp_addr = exp_addr;
      return v;
   endfunction

   function automatic logic [AW-IW-1:0] predict_addr(input vec_t v, input logic [AW-IW-1:0] prev);
      if (v.rst_at >= 0) return '0;
      if (v.addr[AW-1 -: IW] == SID && (v.abort_at < 0 || v.abort_at > AW + 1))
         return v.addr[AW-IW-1:0];
      return prev;
   endfunction

   // Cycle 0 is the start bit; expectations come straight from the frame timing rules.
   task automatic run_frame(input vec_t v, input int id);
      int w, r, nat_end, endc, m_stop;
      bit hit, w_ok, r_ok;
      hit  = (v.addr[AW-1 -: IW] == SID);
      w    = AW + 4 + v.gap;
      r    = AW + 4 + v.gap;
      w_ok = v.rw && v.gap >= 0 && v.gap < TMO - 1;
      r_ok = !v.rw && v.gap >= 1 && v.gap < TMO;
      if (!hit)     nat_end = AW + 2;
      else if (v.rw) nat_end = w_ok ? w + DW + 4 : AW + 4 + TMO;
      else           nat_end = r_ok ? r + DW + 3 : AW + 5 + TMO;
      endc   = nat_end;
      m_stop = nat_end;
      if (v.abort_at >= 0 && v.abort_at < endc) begin
         endc   = v.abort_at + 1;
         m_stop = v.abort_at;
      end
      if (v.rst_at >= 0 && v.rst_at < endc) begin
         endc   = v.rst_at + 1;
         m_stop = v.rst_at + 1;
      end
      for (int k = 0; k <= endc + 1; k++) begin
         bit util, md_oe, md_val, sd_oe, sd_val, e_wr, e_rd, e_busy, e_bus;
         util   = (k < m_stop);
         md_oe  = 1'b0; md_val = 1'b1;
         if (util) begin
            if (k == 0) begin md_oe = 1'b1; md_val = 1'b0; end
            else if (k <= AW) begin md_oe = 1'b1; md_val = v.addr[AW-k]; end
            else if (w_ok && k == w) begin md_oe = 1'b1; md_val = 1'b0; end
            else if (w_ok && k > w && k <= w + DW) begin md_oe = 1'b1; md_val = v.data[DW-1-(k-w-1)]; end
         end
         sd_oe = 1'b0; sd_val = 1'b1; e_wr = 1'b0; e_rd = 1'b0;
         if (hit && k < endc) begin
            if (k == AW + 2 || k == AW + 3) begin sd_oe = 1'b1; sd_val = 1'b0; end
            if (w_ok) begin
               if (k == w + DW + 1) e_wr = 1'b1;
               if (k == w + DW + 2) begin sd_oe = 1'b1; sd_val = 1'b0; end
               if (k == w + DW + 3) begin sd_oe = 1'b1; sd_val = 1'b1; end
            end
            if (!v.rw && k == AW + 4) e_rd = 1'b1;
            if (r_ok) begin
               if (k == r + 1) begin sd_oe = 1'b1; sd_val = 1'b0; end
               if (k == r + 2) begin sd_oe = 1'b1; sd_val = 1'b1; end
               if (k >= r + 3 && k <= r + DW + 2) begin sd_oe = 1'b1; sd_val = v.data[DW-1-(k-r-3)]; end
            end
         end
         e_busy = (k >= 1 && k < endc);
         e_bus  = sd_oe ? sd_val : (md_oe ? md_val : 1'b1);

         rst                 = (k == v.rst_at);
         bus.b_bus_utilizing = util;
         bus.b_RW            = (k == AW) ? v.rw : ~v.rw;
         bus.s_rvalid        = (r_ok && k == r) || (v.early_rv && k == AW + 4);
         bus.s_din           = (k == r) ? v.data : ~v.data;
         m_oe                = md_oe;
         m_val               = md_val;
         #2;
         check($sformatf("f%0d k%0d b_BUS", id, k), 32'(b_BUS), 32'(e_bus));
         check($sformatf("f%0d k%0d s_write", id, k), 32'(bus.s_write), 32'(e_wr));
         check($sformatf("f%0d k%0d s_read", id, k), 32'(bus.s_read), 32'(e_rd));
         check($sformatf("f%0d k%0d s_busy", id, k), 32'(bus.s_busy), 32'(e_busy));
         if (e_wr) begin
            check($sformatf("f%0d s_address at s_write", id), 32'(bus.s_address), 32'(v.addr[AW-IW-1:0]));
            check($sformatf("f%0d s_dout at s_write", id), 32'(bus.s_dout), 32'(v.data));
         end
         if (v.rst_at >= 0 && k == v.rst_at + 1) begin
            check($sformatf("f%0d s_address after rst", id), 32'(bus.s_address), 32'd0);
            check($sformatf("f%0d s_dout after rst", id), 32'(bus.s_dout), 32'd0);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      check($sformatf("f%0d s_address held", id), 32'(bus.s_address), 32'(v.exp_addr));
      addr_model = v.exp_addr;
   endtask

   initial begin
      vecs[0] = mk(15'h5555, 1'b1, 8'hCB, 0,    -1, -1, 1'b0, 12'h555); // write hit
      vecs[1] = mk(15'h5555, 1'b0, 8'hCB, 3,    -1, -1, 1'b0, 12'h555); // read hit, rvalid 3 after s_read
      vecs[2] = mk(15'h1555, 1'b1, 8'h00, 0,    -1, -1, 1'b0, 12'h555); // ID miss
      vecs[3] = mk(15'h5ABC, 1'b1, 8'h3C, 5,    -1, -1, 1'b0, 12'hABC); // delayed data start bit
      vecs[4] = mk(15'h5123, 1'b0, 8'h96, 2,    -1, -1, 1'b0, 12'h123);
      vecs[5] = mk(15'h5555, 1'b1, 8'hFF, 64,   -1, -1, 1'b0, 12'h555); // write timeout
      vecs[6] = mk(15'h5FFF, 1'b0, 8'h00, 1000, -1, -1, 1'b0, 12'hFFF); // read timeout
      vecs[7] = mk(15'h7555, 1'b0, 8'h00, 1,    -1, -1, 1'b0, 12'hFFF); // ID miss, read
      vecs[8] = mk(15'h5ABC, 1'b1, 8'h81, 62,   -1, -1, 1'b0, 12'hABC); // start bit just before timeout
      vecs[9] = mk(15'h5FFF, 1'b0, 8'h5A, 2,    -1, -1, 1'b1, 12'hFFF); // rvalid in s_read cycle ignored

      bus.b_bus_utilizing = 1'b0;
      bus.b_RW            = 1'b0;
      bus.s_rvalid        = 1'b0;
      bus.s_din           = '0;
      rst                 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      check("reset s_busy", 32'(bus.s_busy), 32'd0);
      check("reset s_write", 32'(bus.s_write), 32'd0);
      check("reset s_read", 32'(bus.s_read), 32'd0);
      check("reset s_address", 32'(bus.s_address), 32'd0);
      check("reset s_dout", 32'(bus.s_dout), 32'd0);
      check("reset b_BUS released", 32'(b_BUS), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

      // Abort mid-address (bit 7), abort mid-RD_SEND, then a normal write.
      run_frame(mk(15'h5555, 1'b1, 8'hCB, 0, 7,  -1, 1'b0, 12'hFFF), 20);
      run_frame(mk(15'h5555, 1'b0, 8'hA5, 2, 26, -1, 1'b0, 12'h555), 21);
      run_frame(mk(15'h5555, 1'b1, 8'h96, 1, -1, -1, 1'b0, 12'h555), 22);
      // Reset during WR_DATA, then the next frame must be accepted.
      run_frame(mk(15'h5123, 1'b1, 8'h77, 0, -1, 23, 1'b0, 12'h000), 23);
      run_frame(mk(15'h5555, 1'b1, 8'hCB, 0, -1, -1, 1'b0, 12'h555), 24);

      for (int i = 0; i < 16; i++) begin
         vec_t             v;
         logic [IW-1:0]    id_f;
         id_f       = ($urandom_range(0, 1) == 0) ? SID : IW'($urandom_range(0, 7));
         v.addr     = {id_f, (AW-IW)'($urandom)};
         v.rw       = 1'($urandom_range(0, 1));
         v.data     = DW'($urandom);
         v.gap      = v.rw ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 10));
         v.abort_at = -1;
         v.rst_at   = -1;
         v.early_rv = 1'($urandom_range(0, 1));
         v.exp_addr = predict_addr(v, addr_model);
         run_frame(v, 100 + i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
